// File: rtl/tt_um_akanksha_hu8785_dff_arbiter_pkg.sv
// Shared constants for the four-way round-robin D flip-flop arbiter.
package tt_um_akanksha_hu8785_dff_arbiter_pkg;

  // FSM encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  // Number of requesters and hold counter width
  localparam int NREQ  = 4;
  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  // One-hot decode of a 2-bit requester index
  function automatic logic [NREQ-1:0] onehot4(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

endpackage

// File: rtl/tt_um_akanksha_hu8785_dff_arbiter_rr_pick4.sv
// Combinational round-robin picker: the first active request at or after ptr, wrapping modulo 4.
module rr_pick4
  import tt_um_akanksha_hu8785_dff_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       any,
  output logic [1:0] idx,
  output logic [3:0] onehot
);

  logic [1:0] cand;
  logic       found;

  // Scan ptr, ptr+1, ... and keep the first hit
  always_comb begin
    any   = |req;
    idx   = 2'd0;
    found = 1'b0;
    cand  = ptr;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr + k[1:0];
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    onehot = any ? onehot4(idx) : 4'b0000;
  end

endmodule

// File: rtl/tt_um_akanksha_hu8785_dff_arbiter.sv
// Tiny Tapeout top: four requesters share one registered flop, granted round-robin
// for a bounded hold window. All uo_out bits decode purely from registered state.
module tt_um_akanksha_hu8785_dff_arbiter
  import tt_um_akanksha_hu8785_dff_arbiter_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [3:0] req;
  logic [3:0] data;
  logic       abort;

  logic [1:0] state;
  logic [1:0] ptr;
  logic [1:0] gidx;
  cnt_t       cnt;
  logic       q;

  logic       pick_any;
  logic [1:0] pick_idx;
  logic [3:0] pick_onehot;

  logic       valid;
  logic [3:0] gnt;
  logic       hold_exit;

  assign req   = ui_in[3:0];
  assign data  = ui_in[7:4];
  assign abort = uio_in[0];

  // ena is always high on silicon and the upper uio pins carry nothing
  logic unused;
  assign unused = &{1'b0, ena, uio_in[7:1], pick_onehot};

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (ptr),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Leave HOLD on early release, abort, or an exhausted hold window
  assign hold_exit = !req[gidx] || abort || (cnt == '0);

  // Arbitration FSM with hold counter, priority pointer and the shared flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= 2'd0;
      gidx  <= 2'd0;
      cnt   <= '0;
      q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            gidx  <= pick_idx;
            q     <= data[pick_idx];
            cnt   <= cnt_t'(HOLD_CYCLES - 1);
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          q <= data[gidx];
          if (hold_exit) begin
            state <= ST_RELEASE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RELEASE: begin
          ptr   <= gidx + 2'd1;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign valid = (state == ST_HOLD);
  assign gnt   = valid ? onehot4(gidx) : 4'b0000;

  assign uo_out  = {gidx, gnt, valid, q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule
